// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID -> EX pipeline register sitting right after the register file.
//   - Captures the ID instruction, PC, operands and decoded immediate.
//   - Forwards the WB write into the ID operands. The RF write and the ID read
//     happen on the same edge, so rD1/rD2 would otherwise be stale.
//   - Detects a load in EX feeding the ID instruction, holds ID for one cycle
//     and injects a NOP bubble.
//   - Applies the EX redirect (flush) and counts the load-use bubbles it inserts.
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   inst2, id_valid  ID instruction and its valid flag
//   pc_id            PC of inst2
//   rD1, rD2         RF reads of inst2 rs1/rs2
//   inst5, RegWrite  WB instruction and its write enable
//   WriteData        WB write data
//   flush            EX redirect; kills the ID instruction
//   inst3, ex_valid  EX instruction and its valid flag
//   pc_ex            PC of inst3
//   rs1_ex, rs2_ex   forwarded operands
//   imm_ex           sign-extended immediate of inst3
//   stall_id         hold PC and IF/ID (load-use)
//   bubble_cnt       number of load-use bubbles inserted (wraps)
module id_ex_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst2,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  rD1,
  input  logic [XLEN-1:0]  rD2,
  input  logic [31:0]      inst5,
  input  logic             RegWrite,
  input  logic [XLEN-1:0]  WriteData,
  input  logic             flush,
  output logic [31:0]      inst3,
  output logic             ex_valid,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_ex,
  output logic [XLEN-1:0]  rs2_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      wb_rd;
  logic [4:0]      ex_rd;
  logic            wb_hit1;
  logic            wb_hit2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            use1;
  logic            use2;
  logic            ex_is_load;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            unused_inst5;

  assign opcode  = inst2[6:0];
  assign rs1_idx = inst2[19:15];
  assign rs2_idx = inst2[24:20];
  assign wb_rd   = inst5[11:7];
  assign ex_rd   = inst3[11:7];

  // Only the destination field of the WB instruction matters here.
  assign unused_inst5 = ^{inst5[31:12], inst5[6:0]};

  // WB write-through; x0 is never forwarded.
  assign wb_hit1 = RegWrite && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
  assign wb_hit2 = RegWrite && (wb_rd != 5'd0) && (wb_rd == rs2_idx);
  assign op1     = wb_hit1 ? WriteData : rD1;
  assign op2     = wb_hit2 ? WriteData : rD2;

  // Field bits of unused source registers are immediate bits and must not
  // raise false hazards.
  assign use1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
  assign use2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign ex_is_load = ex_valid && (inst3[6:0] == OP_LOAD) && (ex_rd != 5'd0);
  assign stall_id   = ex_is_load && id_valid &&
                      ((use1 && (ex_rd == rs1_idx)) || (use2 && (ex_rd == rs2_idx)));

  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        imm32 = {{20{inst2[31]}}, inst2[31:20]};
      OP_STORE:
        imm32 = {{20{inst2[31]}}, inst2[31:25], inst2[11:7]};
      OP_BRANCH:
        imm32 = {{19{inst2[31]}}, inst2[31], inst2[7], inst2[30:25], inst2[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst2[31:12], 12'd0};
      OP_JAL:
        imm32 = {{11{inst2[31]}}, inst2[31], inst2[19:12], inst2[20], inst2[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
  end

  assign imm = XLEN'(signed'(imm32));

  // Flush beats stall: a killed instruction must not be counted as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst3      <= NOP_INST;
      ex_valid   <= 1'b0;
      pc_ex      <= '0;
      rs1_ex     <= '0;
      rs2_ex     <= '0;
      imm_ex     <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      inst3    <= NOP_INST;
      ex_valid <= 1'b0;
    end else if (stall_id) begin
      inst3      <= NOP_INST;
      ex_valid   <= 1'b0;
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      inst3    <= id_valid ? inst2 : NOP_INST;
      ex_valid <= id_valid;
      pc_ex    <= pc_id;
      rs1_ex   <= op1;
      rs2_ex   <= op2;
      imm_ex   <= imm;
    end
  end

endmodule
